// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: samples a multiplexed 7-segment bus and rebuilds the displayed 5-digit frame
module seg_scan_decoder #(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 300_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [4:0]  seg_sel_in,
  input  logic [7:0]  seg_led_in,
  output logic [19:0] dig_val,
  output logic [4:0]  dig_blank,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        sel_err,
  output logic        timeout
);
  localparam int CW = $clog2(SETTLE);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CMAX = CW'(SETTLE - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  typedef enum logic {WAIT, HELD} state_t;
  state_t state, state_nx;
  logic [4:0]  sel_s1, sel_s2, sel_d;
  logic [7:0]  led_s1, led_s2, led_d;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tcnt;
  logic [19:0] shadow;
  logic [4:0]  blank, err, mask;
  logic [2:0]  pos;
  logic [3:0]  dec_val;
  logic        dec_bad, change, one_hot, settled, capture, bad_sel, full, tfire;
  assign change  = (sel_s2 != sel_d) || (led_s2 != led_d);
  assign one_hot = $countones(~sel_d) == 1;
  assign settled = state == WAIT && !change && cnt == CMAX;
  assign capture = settled && one_hot;
  assign bad_sel = settled && !one_hot;
  assign full    = &mask;
  assign tfire   = !capture && |mask && !full && tcnt == TMAX;
  // two-flop synchroniser plus a delayed copy for change detection
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      {sel_s1, sel_s2, sel_d} <= {3{5'h1F}};
      {led_s1, led_s2, led_d} <= '0;
    end else begin
      {sel_s1, sel_s2, sel_d} <= {seg_sel_in, sel_s1, sel_s2};
      {led_s1, led_s2, led_d} <= {seg_led_in, led_s1, led_s2};
    end
  // stability counter, saturating once the dwell has settled
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) cnt <= '0;
    else cnt <= change ? '0 : (cnt == CMAX ? cnt : cnt + 1'b1);
  // dwell state register
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) state <= WAIT;
    else state <= state_nx;
  // one capture per dwell; any bus change re-arms
  always_comb state_nx = change ? WAIT : (settled ? HELD : state);
  // position of the single low select bit
  always_comb begin
    pos = '0;
    for (int i = 0; i < 5; i++) if (!sel_d[i]) pos = 3'(i);
  end
  // segment pattern back to a digit; dp bit ignored
  always_comb begin
    {dec_bad, dec_val} = {1'b1, 4'hF};
    case (led_d[6:0])
      7'h3F: {dec_bad, dec_val} = {1'b0, 4'd0};
      7'h06: {dec_bad, dec_val} = {1'b0, 4'd1};
      7'h5B: {dec_bad, dec_val} = {1'b0, 4'd2};
      7'h4F: {dec_bad, dec_val} = {1'b0, 4'd3};
      7'h66: {dec_bad, dec_val} = {1'b0, 4'd4};
      7'h6D: {dec_bad, dec_val} = {1'b0, 4'd5};
      7'h7D: {dec_bad, dec_val} = {1'b0, 4'd6};
      7'h07: {dec_bad, dec_val} = {1'b0, 4'd7};
      7'h7F: {dec_bad, dec_val} = {1'b0, 4'd8};
      7'h6F: {dec_bad, dec_val} = {1'b0, 4'd9};
      7'h00: {dec_bad, dec_val} = {1'b0, 4'hF};
      default: ;
    endcase
  end
  // shadow frame assembly, atomic publish and stale-frame timeout
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      {dig_val, dig_blank, frame_valid, frame_err, sel_err, timeout} <= '0;
      {shadow, blank, err, mask} <= '0;
      tcnt <= '0;
    end else begin
      frame_valid <= 1'b0;
      sel_err <= bad_sel;
      timeout <= tfire;
      if (full) begin
        dig_val <= shadow;
        dig_blank <= blank;
        frame_err <= |err;
        frame_valid <= 1'b1;
        mask <= '0;
        err <= '0;
      end else if (tfire) begin
        mask <= '0;
        err <= '0;
      end
      if (capture) begin
        shadow[{pos, 2'b00} +: 4] <= dec_val;
        blank[pos] <= led_d[6:0] == 7'h00;
        err[pos] <= dec_bad;
        mask[pos] <= 1'b1;
      end
      tcnt <= (capture || full || tfire || mask == '0) ? '0 : tcnt + 1'b1;
    end
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed scenario tests for seg_scan_decoder
module tb_seg_scan_decoder;
  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [4:0]  seg_sel_in = 5'h1F;
  logic [7:0]  seg_led_in = 8'h00;
  logic [19:0] dig_val;
  logic [4:0]  dig_blank;
  logic        frame_valid, frame_err, sel_err, timeout;
  int pass_cnt = 0, total_cnt = 0;
  int fv_cnt = 0, se_cnt = 0, to_cnt = 0;

  seg_scan_decoder #(.SETTLE(4), .TIMEOUT(50)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .seg_sel_in(seg_sel_in), .seg_led_in(seg_led_in),
    .dig_val(dig_val), .dig_blank(dig_blank), .frame_valid(frame_valid),
    .frame_err(frame_err), .sel_err(sel_err), .timeout(timeout)
  );

  always #5 sys_clk = ~sys_clk;

  // pulse counters sampled on the falling edge
  always @(negedge sys_clk) begin
    if (frame_valid) fv_cnt++;
    if (sel_err) se_cnt++;
    if (timeout) to_cnt++;
  end

  task automatic hold(input logic [4:0] s, input logic [7:0] l, input int n);
    seg_sel_in = s;
    seg_led_in = l;
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic clr;
    fv_cnt = 0; se_cnt = 0; to_cnt = 0;
  endtask

  task automatic rotate(input logic [39:0] leds);
    for (int k = 0; k < 5; k++) hold(~(5'b1 << k), leds[8*k +: 8], 10);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge sys_clk);
    total_cnt += 6;
    if (dig_val !== 20'h0) $display("FAIL rst_dig_val got %h want 0", dig_val); else pass_cnt++;
    if (dig_blank !== 5'h0) $display("FAIL rst_dig_blank got %h want 0", dig_blank); else pass_cnt++;
    if (frame_valid !== 1'b0) $display("FAIL rst_frame_valid got %b want 0", frame_valid); else pass_cnt++;
    if (frame_err !== 1'b0) $display("FAIL rst_frame_err got %b want 0", frame_err); else pass_cnt++;
    if (sel_err !== 1'b0) $display("FAIL rst_sel_err got %b want 0", sel_err); else pass_cnt++;
    if (timeout !== 1'b0) $display("FAIL rst_timeout got %b want 0", timeout); else pass_cnt++;
    sys_rst_n = 1'b1;
    hold(5'h1F, 8'h00, 12);
  endtask

  task automatic test_basic;
    clr();
    rotate({8'h06, 8'h3F, 8'h06, 8'h4F, 8'h5B});
    hold(5'h1F, 8'h00, 12);
    total_cnt += 4;
    if (fv_cnt !== 1) $display("FAIL basic_frames got %0d want 1", fv_cnt); else pass_cnt++;
    if (dig_val !== 20'h10132) $display("FAIL basic_dig_val got %h want 10132", dig_val); else pass_cnt++;
    if (dig_blank !== 5'h0) $display("FAIL basic_blank got %b want 00000", dig_blank); else pass_cnt++;
    if (frame_err !== 1'b0) $display("FAIL basic_frame_err got %b want 0", frame_err); else pass_cnt++;
  endtask

  task automatic test_glitch;
    clr();
    hold(5'h1E, 8'h5B, 10);
    hold(5'h1D, 8'h7F, 3);
    hold(5'h1D, 8'h4F, 10);
    hold(5'h1B, 8'h06, 10);
    hold(5'h17, 8'h3F, 10);
    hold(5'h0F, 8'h7F, 3);
    hold(5'h1F, 8'h00, 10);
    total_cnt += 4;
    if (fv_cnt !== 0) $display("FAIL glitch_no_frame got %0d want 0", fv_cnt); else pass_cnt++;
    hold(5'h0F, 8'h06, 10);
    hold(5'h1F, 8'h00, 12);
    if (fv_cnt !== 1) $display("FAIL glitch_frames got %0d want 1", fv_cnt); else pass_cnt++;
    if (dig_val !== 20'h10132) $display("FAIL glitch_dig_val got %h want 10132", dig_val); else pass_cnt++;
    if (frame_err !== 1'b0) $display("FAIL glitch_frame_err got %b want 0", frame_err); else pass_cnt++;
  endtask

  task automatic test_blank_err;
    clr();
    rotate({8'h06, 8'h3F, 8'h00, 8'h4F, 8'h5B});
    hold(5'h1F, 8'h00, 12);
    total_cnt += 6;
    if (dig_val !== 20'h10F32) $display("FAIL blank_dig_val got %h want 10f32", dig_val); else pass_cnt++;
    if (dig_blank !== 5'b00100) $display("FAIL blank_mask got %b want 00100", dig_blank); else pass_cnt++;
    if (frame_err !== 1'b0) $display("FAIL blank_frame_err got %b want 0", frame_err); else pass_cnt++;
    rotate({8'h06, 8'h3F, 8'h77, 8'h4F, 8'h5B});
    hold(5'h1F, 8'h00, 12);
    if (fv_cnt !== 2) $display("FAIL err_frames got %0d want 2", fv_cnt); else pass_cnt++;
    if (dig_val !== 20'h10F32 || dig_blank !== 5'h0)
      $display("FAIL err_dig got %h/%b want 10f32/00000", dig_val, dig_blank); else pass_cnt++;
    if (frame_err !== 1'b1) $display("FAIL err_frame_err got %b want 1", frame_err); else pass_cnt++;
  endtask

  task automatic test_sel_err;
    clr();
    hold(5'h1C, 8'h06, 10);
    total_cnt += 4;
    if (se_cnt !== 1) $display("FAIL selerr_pulses got %0d want 1", se_cnt); else pass_cnt++;
    if (fv_cnt !== 0) $display("FAIL selerr_frames got %0d want 0", fv_cnt); else pass_cnt++;
    if (to_cnt !== 0) $display("FAIL selerr_timeout got %0d want 0", to_cnt); else pass_cnt++;
    if (dig_val !== 20'h10F32) $display("FAIL selerr_dig_val got %h want 10f32", dig_val); else pass_cnt++;
    hold(5'h1F, 8'h00, 12);
  endtask

  task automatic test_timeout;
    int t_at = 0;
    clr();
    hold(5'h1E, 8'h5B, 10);
    seg_sel_in = 5'h1D;
    seg_led_in = 8'h4F;
    for (int i = 1; i <= 80; i++) begin
      @(negedge sys_clk);
      if (i == 10) begin seg_sel_in = 5'h1F; seg_led_in = 8'h00; end
      if (timeout && t_at == 0) t_at = i;
    end
    total_cnt += 5;
    if (t_at !== 57) $display("FAIL timeout_cycle got %0d want 57", t_at); else pass_cnt++;
    if (to_cnt !== 1) $display("FAIL timeout_pulses got %0d want 1", to_cnt); else pass_cnt++;
    if (fv_cnt !== 0) $display("FAIL timeout_frames got %0d want 0", fv_cnt); else pass_cnt++;
    rotate({8'h66, 8'h7D, 8'h6F, 8'h07, 8'h6D});
    hold(5'h1F, 8'h00, 12);
    if (fv_cnt !== 1) $display("FAIL timeout_next_frames got %0d want 1", fv_cnt); else pass_cnt++;
    if (dig_val !== 20'h46975) $display("FAIL timeout_next_dig_val got %h want 46975", dig_val); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    hold(5'h1E, 8'h5B, 10);
    hold(5'h1D, 8'h4F, 10);
    hold(5'h1B, 8'h06, 10);
    sys_rst_n = 1'b0;
    seg_sel_in = 5'h1F;
    seg_led_in = 8'h00;
    #1;
    total_cnt += 7;
    if (dig_val !== 20'h0) $display("FAIL midrst_dig_val got %h want 0", dig_val); else pass_cnt++;
    if (dig_blank !== 5'h0 || frame_err !== 1'b0)
      $display("FAIL midrst_flags got %b/%b want 00000/0", dig_blank, frame_err); else pass_cnt++;
    if (frame_valid !== 1'b0 || sel_err !== 1'b0 || timeout !== 1'b0)
      $display("FAIL midrst_pulses got %b%b%b want 000", frame_valid, sel_err, timeout); else pass_cnt++;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    hold(5'h1F, 8'h00, 12);
    clr();
    hold(5'h17, 8'h3F, 10);
    hold(5'h0F, 8'h06, 10);
    hold(5'h1F, 8'h00, 20);
    if (fv_cnt !== 0) $display("FAIL midrst_frames got %0d want 0", fv_cnt); else pass_cnt++;
    if (dig_val !== 20'h0) $display("FAIL midrst_dig_hold got %h want 0", dig_val); else pass_cnt++;
    rotate({8'h06, 8'h3F, 8'h06, 8'h4F, 8'h5B});
    hold(5'h1F, 8'h00, 12);
    if (fv_cnt !== 1) $display("FAIL midrst_recover_frames got %0d want 1", fv_cnt); else pass_cnt++;
    if (dig_val !== 20'h10132) $display("FAIL midrst_recover_dig got %h want 10132", dig_val); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_blank_err();
    test_sel_err();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
